// File: rtl/stats_collect_pkg.sv
// Shared types for the statistics collector: scanner state encoding.
package stats_collect_pkg;

  typedef enum logic {StIdle, StSweep} scan_state_e;

endpackage

// File: rtl/stats_collect_if.sv
// AXI-stream style (increment, counter ID) output channel toward the counter block.
interface stats_collect_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [ID_WIDTH-1:0]   tid;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tid, output tvalid, input tready);
  modport slave  (input tdata, input tid, input tvalid, output tready);
endinterface

// File: rtl/stats_collect_acc.sv
// Single-channel saturating accumulator; clear reloads with any same-cycle increment.
module stats_collect_acc #(
  parameter int unsigned INC_WIDTH      = 8,
  parameter int unsigned STAT_INC_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INC_WIDTH-1:0]      inc,
  input  logic                      valid,
  input  logic                      clear,
  output logic [STAT_INC_WIDTH-1:0] value,
  output logic                      nonzero,
  output logic                      msb
);

  logic [STAT_INC_WIDTH-1:0] value_q, value_d;
  logic [STAT_INC_WIDTH-1:0] inc_ext;
  logic [STAT_INC_WIDTH:0]   sum;

  always_comb begin
    inc_ext = {{(STAT_INC_WIDTH - INC_WIDTH){1'b0}}, inc};
    sum     = {1'b0, value_q} + {1'b0, inc_ext};
    value_d = value_q;
    if (clear) begin
      // The emitted word took the old value; keep this cycle's event for the next word.
      value_d = valid ? inc_ext : '0;
    end else if (valid) begin
      value_d = sum[STAT_INC_WIDTH] ? '1 : sum[STAT_INC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value   = value_q;
  assign nonzero = |value_q;
  assign msb     = value_q[STAT_INC_WIDTH-1];

endmodule

// File: rtl/stats_collect.sv
// Per-channel event accumulators drained as (increment, id) words by a round-robin scanner.
module stats_collect
  import stats_collect_pkg::*;
#(
  parameter int unsigned CNT            = 8,
  parameter int unsigned INC_WIDTH      = 8,
  parameter int unsigned STAT_INC_WIDTH = 16,
  parameter int unsigned STAT_ID_WIDTH  = 8,
  parameter int unsigned ID_BASE        = 0,
  parameter int unsigned UPDATE_PERIOD  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT*INC_WIDTH-1:0] stat_inc,
  input  logic [CNT-1:0]           stat_valid,
  input  logic                     update,
  stats_collect_if.master          m_axis_stat
);

  localparam int unsigned PtrW = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(CNT - 1);

  logic [STAT_INC_WIDTH-1:0] acc_value [CNT];
  logic [CNT-1:0]            acc_nz, acc_msb, acc_clear;

  for (genvar i = 0; i < CNT; i++) begin : g_ch
    stats_collect_acc #(
      .INC_WIDTH     (INC_WIDTH),
      .STAT_INC_WIDTH(STAT_INC_WIDTH)
    ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .inc    (stat_inc[i*INC_WIDTH +: INC_WIDTH]),
      .valid  (stat_valid[i]),
      .clear  (acc_clear[i]),
      .value  (acc_value[i]),
      .nonzero(acc_nz[i]),
      .msb    (acc_msb[i])
    );
  end

  logic timer_fire;

  if (UPDATE_PERIOD > 0) begin : g_timer
    logic [31:0] timer_q;
    always_ff @(posedge clk) begin
      if (rst || timer_q == '0) timer_q <= 32'(UPDATE_PERIOD - 1);
      else                      timer_q <= timer_q - 32'd1;
    end
    assign timer_fire = (timer_q == '0);
  end else begin : g_no_timer
    assign timer_fire = 1'b0;
  end

  scan_state_e               state_q, state_d;
  logic [PtrW-1:0]           ptr_q, ptr_d;
  logic                      sweep_active_q, sweep_active_d;
  logic [STAT_INC_WIDTH-1:0] tdata_q, tdata_d;
  logic [STAT_ID_WIDTH-1:0]  tid_q, tid_d;
  logic                      tvalid_q, tvalid_d;
  logic                      scan_en, need_emit, slot_free, emit, advance, last;

  always_comb begin
    // The IDLE->SWEEP cycle only rewinds ptr; no channel is examined.
    scan_en   = !(state_q == StIdle && sweep_active_q);
    need_emit = acc_nz[ptr_q] && (state_q == StSweep || acc_msb[ptr_q]);
    slot_free = !tvalid_q || m_axis_stat.tready;
    emit      = scan_en && need_emit && slot_free;
    advance   = scan_en && (!need_emit || slot_free);
    last      = (ptr_q == PtrLast);

    state_d        = state_q;
    ptr_d          = ptr_q;
    sweep_active_d = sweep_active_q;
    tdata_d        = tdata_q;
    tid_d          = tid_q;
    tvalid_d       = tvalid_q && !m_axis_stat.tready;

    for (int i = 0; i < CNT; i++) acc_clear[i] = emit && (ptr_q == PtrW'(i));

    if (!scan_en)     ptr_d = '0;
    else if (advance) ptr_d = last ? '0 : ptr_q + PtrW'(1);

    unique case (state_q)
      StIdle: begin
        if (sweep_active_q) state_d = StSweep;
        if (update || timer_fire) sweep_active_d = 1'b1;
      end
      StSweep: begin
        if (advance && last) begin
          state_d        = StIdle;
          sweep_active_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (emit) begin
      tdata_d  = acc_value[ptr_q];
      tid_d    = STAT_ID_WIDTH'(ID_BASE + 32'(ptr_q));
      tvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      sweep_active_q <= 1'b0;
      tdata_q        <= '0;
      tid_q          <= '0;
      tvalid_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      sweep_active_q <= sweep_active_d;
      tdata_q        <= tdata_d;
      tid_q          <= tid_d;
      tvalid_q       <= tvalid_d;
    end
  end

  assign m_axis_stat.tdata  = tdata_q;
  assign m_axis_stat.tid    = tid_q;
  assign m_axis_stat.tvalid = tvalid_q;

endmodule

// File: tb/tb_stats_collect.sv
// Directed bench: dut_a uses a 64-cycle timer, dut_b has the timer disabled.
module tb_stats_collect;
  import stats_collect_pkg::*;

  localparam int unsigned CNT  = 4;
  localparam int unsigned IW   = 8;
  localparam int unsigned SW   = 16;
  localparam int unsigned DW   = 8;
  localparam int          BASE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic update = 1'b0;
  logic tready = 1'b0;
  logic [CNT*IW-1:0] stat_inc = '0;
  logic [CNT-1:0]    stat_valid = '0;

  stats_collect_if #(.DATA_WIDTH(SW), .ID_WIDTH(DW)) bus_a ();
  stats_collect_if #(.DATA_WIDTH(SW), .ID_WIDTH(DW)) bus_b ();
  assign bus_a.tready = tready;
  assign bus_b.tready = tready;

  always #5 clk = ~clk;

  stats_collect #(
    .CNT(CNT), .INC_WIDTH(IW), .STAT_INC_WIDTH(SW), .STAT_ID_WIDTH(DW),
    .ID_BASE(BASE), .UPDATE_PERIOD(64)
  ) dut_a (
    .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid),
    .update(update), .m_axis_stat(bus_a)
  );

  stats_collect #(
    .CNT(CNT), .INC_WIDTH(IW), .STAT_INC_WIDTH(SW), .STAT_ID_WIDTH(DW),
    .ID_BASE(BASE), .UPDATE_PERIOD(0)
  ) dut_b (
    .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid),
    .update(update), .m_axis_stat(bus_b)
  );

  // Scoreboard of words accepted from dut_a.
  int sum_a [CNT] = '{default: 0};
  int words_a = 0;
  logic [SW-1:0] last_tdata = '0;
  logic [DW-1:0] last_tid = '0;

  always @(posedge clk) begin
    if (!rst && bus_a.tvalid && tready) begin
      sum_a[int'(bus_a.tid) - BASE] <= sum_a[int'(bus_a.tid) - BASE] + int'(bus_a.tdata);
      words_a    <= words_a + 1;
      last_tdata <= bus_a.tdata;
      last_tid   <= bus_a.tid;
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int base_s [CNT];
  int base_w;
  bit ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stat_valid = '0;
    stat_inc = '0;
    update = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [IW-1:0] val, input logic v);
    stat_inc[ch*IW +: IW] = val;
    stat_valid[ch] = v;
  endtask

  task automatic snap();
    base_s = sum_a;
    base_w = words_a;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    step(1);
    update = 1'b0;
  endtask

  task automatic wait_tv(input bit use_b, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (use_b ? bus_b.tvalid : bus_a.tvalid) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    step(2);
    check("rst_tvalid", 32'(bus_a.tvalid), 0);
    check("rst_tdata", 32'(bus_a.tdata), 0);
    check("rst_tid", 32'(bus_a.tid), 0);
    check("rst_tvalid_b", 32'(bus_b.tvalid), 0);

    // Single event on channel 2
    do_reset();
    tready = 1'b1;
    snap();
    set_ch(2, 8'd5, 1'b1);
    step(1);
    set_ch(2, 8'd0, 1'b0);
    pulse_update();
    step(12);
    check("single_words", 32'(words_a - base_w), 1);
    check("single_sum2", 32'(sum_a[2] - base_s[2]), 5);
    check("single_sum0", 32'(sum_a[0] - base_s[0]), 0);
    check("single_sum1", 32'(sum_a[1] - base_s[1]), 0);
    check("single_sum3", 32'(sum_a[3] - base_s[3]), 0);
    check("single_tid", 32'(last_tid), 18);
    check("single_tdata", 32'(last_tdata), 5);

    // Periodic sweep: one timer expiry in 100 cycles, then an update drains the rest
    do_reset();
    tready = 1'b1;
    snap();
    set_ch(0, 8'd1, 1'b1);
    step(100);
    set_ch(0, 8'd0, 1'b0);
    check("period_words_timer", 32'(words_a - base_w), 1);
    check("period_tid", 32'(last_tid), 16);
    pulse_update();
    step(10);
    check("period_words_total", 32'(words_a - base_w), 2);
    check("period_sum0", 32'(sum_a[0] - base_s[0]), 100);

    // Backpressure
    do_reset();
    tready = 1'b0;
    set_ch(0, 8'd3, 1'b1);
    set_ch(1, 8'd7, 1'b1);
    step(1);
    set_ch(0, 8'd0, 1'b0);
    set_ch(1, 8'd0, 1'b0);
    pulse_update();
    wait_tv(1'b0, 10, ok);
    check("bp_wait", 32'(ok), 1);
    check("bp_tdata0", 32'(bus_a.tdata), 3);
    check("bp_tid0", 32'(bus_a.tid), 16);
    step(10);
    check("bp_hold_tvalid", 32'(bus_a.tvalid), 1);
    check("bp_hold_tdata", 32'(bus_a.tdata), 3);
    check("bp_hold_tid", 32'(bus_a.tid), 16);
    tready = 1'b1;
    step(1);
    check("bp_next_tvalid", 32'(bus_a.tvalid), 1);
    check("bp_next_tdata", 32'(bus_a.tdata), 7);
    check("bp_next_tid", 32'(bus_a.tid), 17);
    step(1);
    check("bp_drop_tvalid", 32'(bus_a.tvalid), 0);

    // Emit/increment collision on channel 1
    do_reset();
    tready = 1'b1;
    snap();
    set_ch(1, 8'd9, 1'b1);
    step(1);
    set_ch(1, 8'd0, 1'b0);
    pulse_update();
    step(2);
    set_ch(1, 8'd4, 1'b1);
    step(1);
    set_ch(1, 8'd0, 1'b0);
    check("coll_tvalid", 32'(bus_a.tvalid), 1);
    check("coll_tdata", 32'(bus_a.tdata), 9);
    check("coll_tid", 32'(bus_a.tid), 17);
    step(6);
    pulse_update();
    step(10);
    check("coll_next_tdata", 32'(last_tdata), 4);
    check("coll_sum1", 32'(sum_a[1] - base_s[1]), 13);
    check("coll_words", 32'(words_a - base_w), 2);

    // Overflow guard and saturation on dut_b (no timer, no update)
    do_reset();
    tready = 1'b0;
    set_ch(0, 8'd255, 1'b1);
    wait_tv(1'b1, 200, ok);
    check("thr_wait", 32'(ok), 1);
    check("thr_tdata", 32'(bus_b.tdata), 32'h837C);
    check("thr_tid", 32'(bus_b.tid), 16);
    step(300);
    check("thr_hold_tvalid", 32'(bus_b.tvalid), 1);
    check("thr_hold_tdata", 32'(bus_b.tdata), 32'h837C);
    set_ch(0, 8'd0, 1'b0);
    step(1);
    tready = 1'b1;
    step(1);
    check("sat_tvalid", 32'(bus_b.tvalid), 1);
    check("sat_tdata", 32'(bus_b.tdata), 32'hFFFF);
    check("sat_tid", 32'(bus_b.tid), 16);

    // Reset mid-sweep discards pending words and accumulations
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < CNT; i++) set_ch(i, IW'(i + 1), 1'b1);
    step(1);
    stat_valid = '0;
    pulse_update();
    wait_tv(1'b0, 10, ok);
    check("mid_wait", 32'(ok), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_tvalid", 32'(bus_a.tvalid), 0);
    check("mid_tdata", 32'(bus_a.tdata), 0);
    check("mid_tid", 32'(bus_a.tid), 0);
    tready = 1'b1;
    snap();
    pulse_update();
    step(12);
    check("mid_words", 32'(words_a - base_w), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
